// File: rtl/layernorm_var_acc.sv
// rtl/layernorm_var_acc.sv - streaming N*sum(x^2) - (sum x)^2 pre-stage for the LayerNorm sqrt
module layernorm_var_acc #(
  parameter  int I_W = 8,
  parameter  int N   = 64,
  parameter  int D_W = 32,
  localparam int S_W = I_W + $clog2(N),
  localparam int Q_W = 2 * I_W + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic signed [I_W-1:0] din,
  output logic                  out_valid,
  output logic [D_W-1:0]        qout,
  output logic signed [S_W-1:0] sum_out,
  output logic                  sat
);

  localparam int CW     = $clog2(N);
  localparam int NB     = $clog2(N + 1);
  localparam int P1_W   = Q_W + NB;
  localparam int P2_W   = 2 * S_W;
  localparam int DIFF_W = ((P1_W > P2_W) ? P1_W : P2_W) + 1;

  logic [CW-1:0]         cnt;
  logic signed [S_W-1:0] sum_acc, sum_cap;
  logic [Q_W-1:0]        sumsq_acc, sumsq_cap;
  logic                  v1, v2;
  logic [P1_W-1:0]       p1;
  logic [P2_W-1:0]       p2;

  logic signed [S_W-1:0]   din_ext;
  logic signed [2*I_W-1:0] din_sq;
  logic [Q_W-1:0]          din_sq_ext;
  logic signed [P2_W-1:0]  sum_sq;
  logic [DIFF_W-1:0]       diff;
  logic                    diff_neg, diff_ovf;

  assign din_ext    = S_W'(din);
  assign din_sq     = din * din;
  // The square of a signed value is never negative, so zero-extension is exact.
  assign din_sq_ext = Q_W'($unsigned(din_sq));
  assign sum_sq     = sum_cap * sum_cap;
  assign diff       = DIFF_W'(p1) - DIFF_W'(p2);
  assign diff_neg   = diff[DIFF_W-1];
  assign diff_ovf   = (diff >> D_W) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sum_acc   <= '0;
      sumsq_acc <= '0;
      sum_cap   <= '0;
      sumsq_cap <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      p1        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      qout      <= '0;
      sum_out   <= '0;
      sat       <= 1'b0;
    end else if (enable) begin
      v1 <= 1'b0;
      if (in_valid) begin
        if (cnt == CW'(N - 1)) begin
          sum_cap   <= sum_acc + din_ext;
          sumsq_cap <= sumsq_acc + din_sq_ext;
          sum_acc   <= '0;
          sumsq_acc <= '0;
          cnt       <= '0;
          v1        <= 1'b1;
        end else begin
          sum_acc   <= sum_acc + din_ext;
          sumsq_acc <= sumsq_acc + din_sq_ext;
          cnt       <= cnt + 1'b1;
        end
      end

      v2 <= v1;
      if (v1) begin
        p1 <= P1_W'(sumsq_cap) * P1_W'(N);
        p2 <= $unsigned(sum_sq);
      end

      out_valid <= v2;
      if (v2) begin
        sum_out <= sum_cap;
        // Negative diff cannot happen for real data; clamp to zero defensively.
        if (diff_neg) begin
          qout <= '0;
          sat  <= 1'b0;
        end else if (diff_ovf) begin
          qout <= '1;
          sat  <= 1'b1;
        end else begin
          qout <= D_W'(diff);
          sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_layernorm_var_acc.sv
// tb/tb_layernorm_var_acc.sv - scoreboard bench for layernorm_var_acc (N=4, I_W=8, D_W=16)
module tb_layernorm_var_acc;

  localparam int I_W = 8;
  localparam int N   = 4;
  localparam int D_W = 16;
  localparam int S_W = I_W + $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  in_valid;
  logic signed [I_W-1:0] din;
  logic                  out_valid;
  logic [D_W-1:0]        qout;
  logic signed [S_W-1:0] sum_out;
  logic                  sat;

  layernorm_var_acc #(.I_W(I_W), .N(N), .D_W(D_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .din(din),
    .out_valid(out_valid), .qout(qout), .sum_out(sum_out), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint q;
    longint s;
    longint sat;
    int     due;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  longint m_sq = 0;
  int     en_edges = 0;
  bit     last_en = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle and advance the reference model on the same edge.
  task automatic drive(input bit r, input bit e, input bit v, input int d);
    exp_t x;
    longint diff;
    rst = r; enable = e; in_valid = v; din = I_W'(d);
    @(posedge clk);
    last_en = !r && e;
    if (r) begin
      m_cnt = 0; m_sum = 0; m_sq = 0;
      sb.delete();
    end else if (e) begin
      en_edges++;
      if (v) begin
        m_sum += d;
        m_sq  += d * d;
        if (m_cnt == N - 1) begin
          diff  = N * m_sq - m_sum * m_sum;
          x.s   = m_sum;
          x.due = en_edges + 2;
          if (diff < 0) begin
            x.q = 0; x.sat = 0;
          end else if (diff > 65535) begin
            x.q = 65535; x.sat = 1;
          end else begin
            x.q = diff; x.sat = 0;
          end
          sb.push_back(x);
          m_cnt = 0; m_sum = 0; m_sq = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic row(input int a, input int b, input int c, input int d);
    drive(0, 1, 1, a);
    drive(0, 1, 1, b);
    drive(0, 1, 1, c);
    drive(0, 1, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0);
  endtask

  // Every enabled edge either produces the next scoreboard entry on time or nothing.
  always @(negedge clk) begin
    exp_t x;
    if (last_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("valid_when_idle", 64'(out_valid), 0);
        end else begin
          x = sb.pop_front();
          chk("latency_edge", en_edges, x.due);
          chk("qout", 64'(qout), x.q);
          chk("sum_out", sum_out, x.s);
          chk("sat", 64'(sat), x.sat);
        end
      end else if (sb.size() > 0 && sb[0].due <= en_edges) begin
        chk("out_valid_missing", 64'(out_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  logic [D_W-1:0]        hold_q;
  logic signed [S_W-1:0] hold_s;
  logic                  hold_sat;

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; din = '0;
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_qout", 64'(qout), 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_sat", 64'(sat), 0);
    idle(2);

    row(1, 2, 3, 4);
    idle(4);

    row(-5, -5, -5, -5);
    row(0, 0, 0, 8);
    idle(4);

    row(127, -128, 127, -128);
    idle(4);

    // Gaps in in_valid mid-row, then an enable stall inside the result pipeline.
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 2);
    idle(3);
    drive(0, 1, 1, 3);
    drive(0, 1, 1, 4);
    hold_q = qout; hold_s = sum_out; hold_sat = sat;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 99);
      chk("stall_out_valid", 64'(out_valid), 0);
      chk("stall_qout", 64'(qout), 64'(hold_q));
      chk("stall_sum_out", sum_out, hold_s);
      chk("stall_sat", 64'(sat), 64'(hold_sat));
    end
    idle(4);

    // Aborted partial row must never produce a result.
    drive(0, 1, 1, 9);
    drive(0, 1, 1, 9);
    drive(1, 1, 0, 0);
    chk("rst2_out_valid", 64'(out_valid), 0);
    chk("rst2_qout", 64'(qout), 0);
    chk("rst2_sum_out", sum_out, 0);
    row(1, 2, 3, 4);
    idle(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
